// File: rtl/adc_scan_arbiter.sv
// adc_scan_arbiter: round-robin sharing of one ADC128S022-style SPI ADC among NREQ requesters.
// Define ADC_ARB_AVG_EN to run four data frames per grant and return their average.
module adc_scan_arbiter #(
    parameter int NREQ    = 3,
    parameter int SCK_DIV = 10
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [3*NREQ-1:0] req_ch,
    output logic [NREQ-1:0]   done,
    output logic [11:0]       result,
    output logic              busy,
    output logic              adc_cs_n,
    output logic              adc_sck,
    output logic              adc_add,
    input  logic              adc_data
);
`ifdef ADC_ARB_AVG_EN
    localparam int N_CONV = 4;
`else
    localparam int N_CONV = 1;
`endif
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(2 * SCK_DIV);

    typedef enum logic [2:0] {IDLE, START, SHIFT, QUIET, DONE} state_t;

    state_t         state, state_n;
    logic [CW-1:0]  cnt;
    logic [3:0]     per, per_n;
    logic [IDW-1:0] gnt_id, rr_ptr, sel_id, idx;
    logic [2:0]     gnt_ch, last_ch, sel_ch;
    logic [2:0]     ch_arr [NREQ];
    logic [2:0]     frames_left;
    logic [11:0]    sh;
    logic           cnt_end, add_n;
`ifdef ADC_ARB_AVG_EN
    logic [13:0]    acc;
    logic           prime;
`endif

    // Unpack the per-requester channel fields.
    always_comb begin
        for (int i = 0; i < NREQ; i++) ch_arr[i] = req_ch[3*i +: 3];
    end

    // Round-robin pick: first set request at or after rr_ptr, wrapping; lowest offset wins.
    always_comb begin
        idx    = '0;
        sel_id = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr) + k) % NREQ);
            if (req[idx]) sel_id = idx;
        end
        sel_ch = ch_arr[sel_id];
    end

    // State register.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    // Next state, phase-counter terminal count and the address bit for the upcoming sck period.
    always_comb begin
        state_n = state;
        cnt_end = 1'b1;
        per_n   = per + 4'd1;
        add_n   = (per_n == 4'd2) ? gnt_ch[2] : (per_n == 4'd3) ? gnt_ch[1] : (per_n == 4'd4) ? gnt_ch[0] : 1'b0;
        case (state)
            IDLE: if (|req) state_n = START;
            START: begin
                cnt_end = cnt == CW'(SCK_DIV - 1);
                if (cnt_end) state_n = SHIFT;
            end
            SHIFT: begin
                cnt_end = cnt == CW'(SCK_DIV - 1);
                if (cnt_end && adc_sck && per == 4'd15) state_n = QUIET;
            end
            QUIET: begin
                cnt_end = cnt == CW'(2 * SCK_DIV - 1);
                if (cnt_end) state_n = (frames_left != 3'd0) ? START : DONE;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: grant latch, SPI sequencing, DOUT sampling and completion.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            per         <= '0;
            gnt_id      <= '0;
            gnt_ch      <= '0;
            last_ch     <= '0;
            rr_ptr      <= '0;
            frames_left <= '0;
            sh          <= '0;
            done        <= '0;
            result      <= '0;
            busy        <= 1'b0;
            adc_cs_n    <= 1'b1;
            adc_sck     <= 1'b1;
            adc_add     <= 1'b0;
`ifdef ADC_ARB_AVG_EN
            acc         <= '0;
            prime       <= 1'b0;
`endif
        end else begin
            cnt  <= cnt_end ? '0 : cnt + 1'b1;
            done <= '0;
            case (state)
                IDLE: if (|req) begin
                    gnt_id      <= sel_id;
                    gnt_ch      <= sel_ch;
                    frames_left <= (sel_ch != last_ch) ? 3'(N_CONV + 1) : 3'(N_CONV);
                    busy        <= 1'b1;
                    adc_cs_n    <= 1'b0;
                    adc_sck     <= 1'b1;
`ifdef ADC_ARB_AVG_EN
                    acc         <= '0;
                    prime       <= sel_ch != last_ch;
`endif
                end
                START: if (cnt_end) begin
                    adc_sck <= 1'b0;
                    per     <= '0;
                    adc_add <= 1'b0;
                end
                SHIFT: if (cnt_end) begin
                    if (!adc_sck) begin
                        adc_sck <= 1'b1;
                        sh      <= {sh[10:0], adc_data};
                    end else if (per == 4'd15) begin
                        adc_cs_n    <= 1'b1;
                        last_ch     <= gnt_ch;
                        frames_left <= frames_left - 1'b1;
`ifdef ADC_ARB_AVG_EN
                        acc         <= prime ? acc : acc + {2'b00, sh};
                        prime       <= 1'b0;
`endif
                    end else begin
                        per     <= per_n;
                        adc_sck <= 1'b0;
                        adc_add <= add_n;
                    end
                end
                QUIET: if (cnt_end) begin
                    if (frames_left != 3'd0) adc_cs_n <= 1'b0;
                    else begin
                        done[gnt_id] <= 1'b1;
                        busy         <= 1'b0;
`ifdef ADC_ARB_AVG_EN
                        result       <= acc[13:2];
`else
                        result       <= sh;
`endif
                    end
                end
                DONE: rr_ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_scan_arbiter.sv
// tb_adc_scan_arbiter: table-driven and sequence tests of adc_scan_arbiter against an ADC128S022 model.
module tb_adc_scan_arbiter;
    localparam int NREQ    = 3;
    localparam int SCK_DIV = 10;
`ifdef ADC_ARB_AVG_EN
    localparam int N_CONV = 4;
`else
    localparam int N_CONV = 1;
`endif
    localparam int FRAME   = 35 * SCK_DIV;
    localparam int TXN_MAX = (N_CONV + 1) * FRAME + 20;

    logic              clk_50 = 1'b0;
    logic              rst_n  = 1'b0;
    logic [NREQ-1:0]   req    = '0;
    logic [3*NREQ-1:0] req_ch = '0;
    logic [NREQ-1:0]   done;
    logic [11:0]       result;
    logic              busy, adc_cs_n, adc_sck, adc_add;
    logic              adc_data = 1'b0;

    int checks = 0, failures = 0, cyc = 0;

    typedef struct {int id; logic [11:0] val; logic [2:0] ch; int frames; int t0;} exp_t;
    typedef struct {logic [2:0] r; logic [8:0] chs; int id; logic [2:0] ch; bit prime;} vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t tv[6];

    logic [11:0] mem [8] = '{12'h5A3, 12'h111, 12'h222, 12'h0F0, 12'h444, 12'h3C7, 12'h666, 12'hABC};
    int          ovr_q[$];
    int          adc_p = 0, frames_seen = 0;
    logic [2:0]  adc_cur = 3'd0, adc_addr = 3'd0;
    logic [15:0] adc_sh = '0;
    logic        p_sck = 1'b1, p_cs = 1'b1, p_add = 1'b0;

    adc_scan_arbiter #(.NREQ(NREQ), .SCK_DIV(SCK_DIV)) dut (
        .clk_50(clk_50), .rst_n(rst_n), .req(req), .req_ch(req_ch), .done(done), .result(result),
        .busy(busy), .adc_cs_n(adc_cs_n), .adc_sck(adc_sck), .adc_add(adc_add), .adc_data(adc_data)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_50);
        #2;
    endtask

    // ADC model: converts the channel addressed in the previous complete frame.
    always @(negedge adc_cs_n) begin
        adc_p = 0;
        frames_seen++;
        if (ovr_q.size() > 0) adc_sh = {4'b0, 12'(ovr_q.pop_front())};
        else adc_sh = {4'b0, mem[adc_cur]};
        adc_data = 1'b0;
    end

    always @(negedge adc_sck) begin
        if (!adc_cs_n) begin
            adc_p++;
            adc_data = adc_sh[15];
            adc_sh   = adc_sh << 1;
        end
    end

    always @(posedge adc_sck) begin
        if (!adc_cs_n && adc_p >= 3 && adc_p <= 5) adc_addr = {adc_addr[1:0], adc_add};
    end

    always @(posedge adc_cs_n) begin
        if (adc_p >= 5) adc_cur = adc_addr;
        if (adc_p == 16 && sb.size() > 0) chk("frame_addr", adc_addr, sb[0].ch);
    end

    // Scoreboard monitor on done pulses.
    always @(negedge clk_50) begin
        if (rst_n && done != '0) begin
            if (sb.size() == 0) chk("unexpected_done", done, 0);
            else begin
                mon_e = sb.pop_front();
                chk("done_onehot", done, 32'(1) << mon_e.id);
                chk("result", result, mon_e.val);
                chk("frame_count", frames_seen, mon_e.frames);
                if (mon_e.t0 >= 0) chk("latency", cyc - mon_e.t0 + 1, 2 + mon_e.frames * FRAME);
            end
            frames_seen = 0;
        end
    end

    // Protocol monitor: adc_add moves only on sck falls; sck never toggles with cs_n high.
    always @(negedge clk_50) begin
        if (adc_add !== p_add) chk("add_on_sck_fall", {p_sck, adc_sck}, 2'b10);
        if (adc_sck !== p_sck) chk("sck_toggle_cs_high", {p_cs, adc_cs_n} == 2'b11, 0);
        p_sck = adc_sck;
        p_cs  = adc_cs_n;
        p_add = adc_add;
    end

    task automatic wait_empty(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        chk("done_in_time", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_txn(input logic [2:0] r, input logic [8:0] chs, input int id,
                           input logic [2:0] ch, input bit prime, input logic [11:0] val);
        exp_t e;
        e.id = id; e.ch = ch; e.val = val; e.frames = N_CONV + int'(prime); e.t0 = cyc;
        sb.push_back(e);
        req    = r;
        req_ch = chs;
        tick();
        tick();
        chk("busy_in_txn", busy, 1);
        chk("cs_low_in_txn", adc_cs_n, 0);
        req    = '0;
        req_ch = ~chs;
        wait_empty(TXN_MAX);
        repeat (3) tick();
        chk("result_hold", result, val);
    endtask

    initial begin
        #(200_000 * 20);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tv[0] = '{3'b001, {3'd0, 3'd0, 3'd0}, 0, 3'd0, 1'b0};
        tv[1] = '{3'b010, {3'd0, 3'd5, 3'd0}, 1, 3'd5, 1'b1};
        tv[2] = '{3'b001, {3'd0, 3'd0, 3'd5}, 0, 3'd5, 1'b0};
        tv[3] = '{3'b101, {3'd3, 3'd0, 3'd7}, 2, 3'd3, 1'b1};
        tv[4] = '{3'b110, {3'd1, 3'd7, 3'd0}, 1, 3'd7, 1'b1};
        tv[5] = '{3'b100, {3'd7, 3'd0, 3'd0}, 2, 3'd7, 1'b0};
        repeat (3) tick();
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_sck", adc_sck, 1);
        chk("rst_add", adc_add, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (3) tick();
        for (int i = 0; i < 6; i++) run_txn(tv[i].r, tv[i].chs, tv[i].id, tv[i].ch, tv[i].prime, mem[tv[i].ch]);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.id = i % NREQ; e.ch = 3'd7; e.val = mem[7]; e.frames = N_CONV; e.t0 = (i == 0) ? cyc : -1;
            sb.push_back(e);
        end
        req    = 3'b111;
        req_ch = {3'd7, 3'd7, 3'd7};
        wait_empty(4 * TXN_MAX);
        req = '0;
        repeat (10) tick();
        begin
            int n = 0;
            req    = 3'b001;
            req_ch = '0;
            while (!(adc_p == 8 && !adc_sck && !adc_cs_n) && n < TXN_MAX) begin
                tick();
                n++;
            end
            chk("reach_period8", adc_p, 8);
            #3;
            rst_n = 1'b0;
            req   = '0;
            #1;
            chk("abort_cs_n", adc_cs_n, 1);
            chk("abort_sck", adc_sck, 1);
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            repeat (3) tick();
            rst_n       = 1'b1;
            frames_seen = 0;
            repeat (40) tick();
        end
        run_txn(3'b001, 9'd0, 0, 3'd0, 1'b0, mem[0]);
`ifdef ADC_ARB_AVG_EN
        ovr_q = '{100, 101, 102, 104};
        run_txn(3'b001, 9'd0, 0, 3'd0, 1'b0, 12'd101);
`endif
        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
